cmp_result_serializer: RTL and testbench
========================================

Name: cmp_result_serializer

Overview:
- Parallel-in, serial-out collector on the result side of the mul17 compressor test harness.
- The input harness shifts serial operand bits into the column registers. This block does the reverse: it latches the NUM_COLS single-bit compressor outputs (dst0..dst33, packed as one bus) and streams them out LSB-first over a valid/ready serial link.
- For each frame it also reports a parity bit and a frame count, so the bench or a host can check results with a single output pin.

Parameters:
- NUM_COLS, 34, number of compressor output columns; each column is 1 bit.
- CNT_W, 16, width of the frame counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- dst  in  NUM_COLS  packed compressor outputs; bit i is dst<i>.
- capture  in  1  request to latch dst.
- out_bit  out  1  current serial bit.
- out_valid  out  1  out_bit is valid.
- out_ready  in  1  sink accepts out_bit.
- out_last  out  1  marks the final bit of the frame (bit NUM_COLS-1).
- done  out  1  one-cycle pulse after the last handshake.
- parity  out  1  XOR of all bits of the last completed frame.
- frame_cnt  out  CNT_W  number of completed frames.
- overrun  out  1  sticky flag: a capture was dropped.
- clr_overrun  in  1  synchronous clear of overrun.

Behaviour:
- Reset values (applied asynchronously): shift register 0, bit index 0, state IDLE, out_valid 0, out_last 0, out_bit 0, done 0, parity 0, frame_cnt 0, overrun 0.
- FSM has two states, IDLE and SHIFT.
- IDLE with capture=1 at edge t:
  - shreg <= dst, idx <= 0, running parity <= 0, state <= SHIFT.
  - From cycle t+1: out_valid=1, out_bit=dst[0]. Latency is 1 cycle.
- SHIFT:
  - out_bit = shreg[0] and out_valid = 1.
  - out_bit holds while out_ready=0 (no bit may be lost or duplicated).
  - On handshake (out_valid & out_ready): shreg shifts right by one, idx increments, running parity ^= out_bit.
  - out_last = 1 exactly when idx == NUM_COLS-1.
  - A handshake with out_last=1 ends the frame:
    - state <= IDLE.
    - done = 1 for the next cycle.
    - parity <= running parity ^ out_bit.
    - frame_cnt increments; it wraps from 2^CNT_W-1 to 0.
- Back-to-back frames: a capture in the same cycle as the last handshake is accepted. The next frame starts and out_valid stays 1 with no bubble. done still pulses and parity/frame_cnt update for the old frame. This is not an overrun.
- capture in SHIFT, other than on the last-handshake cycle, is ignored and sets overrun. The frame in flight is unaffected.
- overrun clears only via clr_overrun. If a set condition and clr_overrun occur in the same cycle, set wins.
- dst is sampled only on the accepting capture edge. Later changes to dst do not affect the frame.
- parity and frame_cnt stay stable between frames.
- rst asserted mid-frame: out_valid drops immediately and the frame is discarded. There is no done pulse and frame_cnt does not increment. After rst deasserts, the block is in IDLE.
- Bit index width is clog2(NUM_COLS). NUM_COLS >= 2 is required.

Decomposition:
- Shared package cmp_harness_pkg holds:
  - mul17 column constants: NUM_COLS=34, operand width 17, and the column-height function h(i)=min(i+1, 33-i) for i<33.
  - The state enum {IDLE, SHIFT}.
- One natural sub-module, piso_shreg: a loadable shift register with load/shift enables and async reset. FSM, parity and counters stay in the top level.

Test Plan:
- Single frame: dst=34'h2_AAAA_5555, capture for one cycle, out_ready=1 constantly. Required: out_valid from t+1 for exactly 34 cycles; serial bits reconstruct 34'h2_AAAA_5555; out_last only on the 34th bit; done pulses once; parity=1 (17 ones); frame_cnt=1.
- Backpressure: same frame with out_ready toggling 1,0,0,1,... Required: out_bit held stable while out_ready=0; 34 handshakes in total; same reconstructed value and parity.
- Back-to-back: frame A=34'h0, then capture frame B=34'h3_FFFF_FFFF on A's last-handshake cycle. Required: no out_valid gap; overrun=0; after A, parity=0 and frame_cnt=1; after B, parity=0 (34 ones) and frame_cnt=2.
- Overrun: capture at bit index 10 of a frame. Required: the frame continues unchanged and overrun=1. clr_overrun then gives overrun=0. Capture and clr_overrun in the same cycle at index 20 leaves overrun=1.
- Reset mid-frame: assert rst at bit 15. Required: out_valid=0 in the same cycle; no done pulse; frame_cnt unchanged (0). A later capture streams a full frame correctly.
- Counter wrap: with CNT_W=2, run 5 frames. Required: frame_cnt sequence 1,2,3,0,1.

Source files
------------

// File: rtl/cmp_harness_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cmp_harness_pkg
// Brief    : Shared mul17 compressor harness constants, types and helpers.
// Revision : 1.0 - initial release
// ============================================================================
package cmp_harness_pkg;

    localparam int c_NUM_COLS  = 34;
    localparam int c_OPERAND_W = 17;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Partial-product column height of the 17x17 array, valid for col < c_NUM_COLS-1.
    function automatic int col_height(input int col);
        int h_lo;
        int h_hi;
        h_lo = col + 1;
        h_hi = (c_NUM_COLS - 1) - col;
        return (h_lo < h_hi) ? h_lo : h_hi;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmp_result_serializer_piso_shreg.sv
`default_nettype none
// ============================================================================
// Module   : piso_shreg
// Brief    : Loadable parallel-in serial-out shift register, LSB first.
// Revision : 1.0 - initial release
// ============================================================================
module piso_shreg
    import cmp_harness_pkg::*;
#(
    parameter int WIDTH = c_NUM_COLS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             sout
);

    logic [WIDTH-1:0] r_shreg;

    // Load wins over shift so a back-to-back frame replaces the drained one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg <= '0;
        end else if (load) begin
            r_shreg <= din;
        end else if (shift) begin
            r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
        end
    end

    assign sout = r_shreg[0];

endmodule
`default_nettype wire

// File: rtl/cmp_result_serializer.sv
`default_nettype none
// ============================================================================
// Module   : cmp_result_serializer
// Brief    : Latches the compressor column outputs and streams them LSB-first
//            over a valid/ready link with per-frame parity and frame count.
// Revision : 1.0 - initial release
// ============================================================================
module cmp_result_serializer
    import cmp_harness_pkg::*;
#(
    parameter int NUM_COLS = c_NUM_COLS,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_COLS-1:0] dst,
    input  logic                capture,
    output logic                out_bit,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic                done,
    output logic                parity,
    output logic [CNT_W-1:0]    frame_cnt,
    output logic                overrun,
    input  logic                clr_overrun
);

    localparam int                 c_IDX_W    = $clog2(NUM_COLS);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_COLS - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_IDX_W-1:0] r_idx;
    logic               r_run_par;
    logic               r_done;
    logic               r_parity;
    logic [CNT_W-1:0]   r_frame_cnt;
    logic               r_overrun;

    logic               w_sout;
    logic               w_hs;
    logic               w_last_hs;
    logic               w_accept;
    logic               w_drop;

    piso_shreg #(
        .WIDTH (NUM_COLS)
    ) u_piso_shreg (
        .clk   (clk),
        .rst   (rst),
        .load  (w_accept),
        .shift (w_hs),
        .din   (dst),
        .sout  (w_sout)
    );

    assign w_hs      = out_valid & out_ready;
    assign w_last_hs = w_hs & out_last;
    // A capture on the final handshake chains the next frame without a bubble.
    assign w_accept  = capture & ((r_state == IDLE) | w_last_hs);
    assign w_drop    = capture & (r_state == SHIFT) & ~w_last_hs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (capture) begin
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (w_last_hs && !capture) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        out_bit   = 1'b0;
        out_last  = 1'b0;
        if (r_state == SHIFT) begin
            out_valid = 1'b1;
            out_bit   = w_sout;
            out_last  = (r_idx == c_LAST_IDX);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx       <= '0;
            r_run_par   <= 1'b0;
            r_done      <= 1'b0;
            r_parity    <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_done <= w_last_hs;
            if (w_accept || w_last_hs) begin
                r_idx <= '0;
            end else if (w_hs) begin
                r_idx <= r_idx + c_IDX_W'(1);
            end
            if (w_accept) begin
                r_run_par <= 1'b0;
            end else if (w_hs) begin
                r_run_par <= r_run_par ^ w_sout;
            end
            if (w_last_hs) begin
                r_parity    <= r_run_par ^ w_sout;
                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end
        end
    end

    // Setting a dropped capture has priority over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (clr_overrun) begin
            r_overrun <= 1'b0;
        end
    end

    assign done      = r_done;
    assign parity    = r_parity;
    assign frame_cnt = r_frame_cnt;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_cmp_result_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmp_result_serializer
// Brief    : Self-checking bench with a frame-queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmp_result_serializer;

    localparam int NC = 34;

    logic          clk = 1'b0;
    logic          rst;
    logic [NC-1:0] dst;
    logic          capture;
    logic          out_ready;
    logic          clr_overrun;

    logic          out_bit, out_valid, out_last, done, parity, overrun;
    logic [15:0]   frame_cnt;
    logic          out_bit2, out_valid2, out_last2, done2, parity2, overrun2;
    logic [1:0]    frame_cnt2;

    always #5 clk = ~clk;

    cmp_result_serializer #(.NUM_COLS(NC), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .dst(dst), .capture(capture),
        .out_bit(out_bit), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .done(done), .parity(parity),
        .frame_cnt(frame_cnt), .overrun(overrun), .clr_overrun(clr_overrun)
    );

    cmp_result_serializer #(.NUM_COLS(NC), .CNT_W(2)) dut_w2 (
        .clk(clk), .rst(rst), .dst(dst), .capture(capture),
        .out_bit(out_bit2), .out_valid(out_valid2), .out_ready(out_ready),
        .out_last(out_last2), .done(done2), .parity(parity2),
        .frame_cnt(frame_cnt2), .overrun(overrun2), .clr_overrun(clr_overrun)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: the frame in flight is a queue of remaining bits.
    bit mq[$];
    bit m_run, m_par, m_done, m_ovr;
    int m_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_run = 0; m_par = 0; m_done = 0; m_ovr = 0; m_cnt = 0;
        end else begin
            bit act, hs, ending, b;
            act    = (mq.size() != 0);
            hs     = act && out_ready;
            ending = hs && (mq.size() == 1);
            m_done = 0;
            if (hs) begin
                b = mq.pop_front();
                m_run ^= b;
            end
            if (ending) begin
                m_done = 1;
                m_par  = m_run;
                m_cnt++;
            end
            if (capture && (!act || ending)) begin
                m_run = 0;
                for (int i = 0; i < NC; i++) mq.push_back(dst[i]);
            end
            if (act && capture && !ending) m_ovr = 1;
            else if (clr_overrun)          m_ovr = 0;
        end
    end

    always @(negedge clk) begin
        bit ev;
        ev = (mq.size() != 0);
        check("out_valid", out_valid, ev);
        check("out_valid_w2", out_valid2, ev);
        if (ev) begin
            check("out_bit", out_bit, mq[0]);
            check("out_bit_w2", out_bit2, mq[0]);
            check("out_last", out_last, mq.size() == 1);
        end
        check("done", done, m_done);
        check("done_w2", done2, m_done);
        check("parity", parity, m_par);
        check("parity_w2", parity2, m_par);
        check("frame_cnt", frame_cnt, m_cnt % 65536);
        check("frame_cnt_w2", frame_cnt2, m_cnt % 4);
        check("overrun", overrun, m_ovr);
        check("overrun_w2", overrun2, m_ovr);
        if (!ev) check("out_last_idle_w2", out_last2, 0);
    end

    // Per-run accumulators of what the DUT actually streamed.
    logic [67:0] g_val;
    int g_nhs, g_nvalid, g_nlast, g_lastpos, g_ndone, g_cyc;
    logic g_dpar;
    logic [15:0] g_dcnt;
    logic g_pv, g_pr, g_pb;

    task automatic clear_acc();
        g_val = '0; g_nhs = 0; g_nvalid = 0; g_nlast = 0; g_lastpos = -1;
        g_ndone = 0; g_cyc = 0; g_dpar = 0; g_dcnt = 0;
        g_pv = 0; g_pr = 0; g_pb = 0;
    endtask

    task automatic sample();
        if (g_pv && !g_pr && out_valid) check("hold_bit", out_bit, g_pb);
        if (out_valid) g_nvalid++;
        if (out_valid && out_ready) begin
            if (g_nhs < 68) g_val[g_nhs] = out_bit;
            if (out_last) begin
                g_nlast++;
                g_lastpos = g_nhs;
            end
            g_nhs++;
        end
        if (done) begin
            g_ndone++;
            if (g_ndone == 1) begin
                g_dpar = parity;
                g_dcnt = frame_cnt;
            end
        end
        g_pv = out_valid; g_pr = out_ready; g_pb = out_bit;
    endtask

    task automatic run_until(input int target, input int mode, input int cap_at,
                             input int clr_at, input logic [NC-1:0] capdst);
        int guard;
        guard = 0;
        while (g_nhs < target && guard < 400) begin
            out_ready   = (mode == 0) ? 1'b1 : (g_cyc % 3 == 0);
            capture     = (g_nhs == cap_at);
            clr_overrun = (g_nhs == clr_at);
            if (g_nhs == cap_at) dst = capdst;
            @(negedge clk);
            sample();
            @(posedge clk); #1;
            g_cyc++;
            guard++;
        end
        capture = 0;
        clr_overrun = 0;
        if (guard >= 400) check("run_timeout", g_nhs, target);
    endtask

    task automatic tail();
        capture = 0;
        clr_overrun = 0;
        @(negedge clk);
        sample();
        @(posedge clk); #1;
    endtask

    task automatic start_frame(input logic [NC-1:0] d);
        capture = 1; dst = d;
        @(posedge clk); #1;
        capture = 0; dst = ~d;
        clear_acc();
    endtask

    task automatic do_reset();
        rst = 1; capture = 0; clr_overrun = 0; out_ready = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        clear_acc();
    endtask

    int wrap_exp[5] = '{1, 2, 3, 0, 1};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; dst = '0; capture = 0; out_ready = 0; clr_overrun = 0;
        clear_acc();

        // Reset state
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_bit", out_bit, 0);
        check("rst_done", done, 0);
        check("rst_parity", parity, 0);
        check("rst_cnt", frame_cnt, 0);
        check("rst_ovr", overrun, 0);
        @(posedge clk); #1 rst = 0;

        // Single frame, sink always ready
        start_frame(34'h2_AAAA_5555);
        run_until(34, 0, -1, -1, '0);
        tail();
        check("t1_value", g_val[33:0], 34'h2_AAAA_5555);
        check("t1_nvalid", g_nvalid, 34);
        check("t1_nlast", g_nlast, 1);
        check("t1_lastpos", g_lastpos, 33);
        check("t1_ndone", g_ndone, 1);
        check("t1_parity", parity, 1);
        check("t1_cnt", frame_cnt, 1);

        // Backpressure 1,0,0,1,...
        do_reset();
        start_frame(34'h2_AAAA_5555);
        run_until(34, 1, -1, -1, '0);
        tail();
        check("t2_value", g_val[33:0], 34'h2_AAAA_5555);
        check("t2_lastpos", g_lastpos, 33);
        check("t2_ndone", g_ndone, 1);
        check("t2_parity", parity, 1);
        check("t2_cnt", frame_cnt, 1);

        // Back-to-back frames
        do_reset();
        start_frame(34'h0);
        run_until(68, 0, 33, -1, 34'h3_FFFF_FFFF);
        tail();
        check("t3_valA", g_val[33:0], 34'h0);
        check("t3_valB", g_val[67:34], 34'h3_FFFF_FFFF);
        check("t3_nogap", g_nvalid, 68);
        check("t3_parA", g_dpar, 0);
        check("t3_cntA", g_dcnt, 1);
        check("t3_ndone", g_ndone, 2);
        check("t3_parB", parity, 0);
        check("t3_cntB", frame_cnt, 2);
        check("t3_ovr", overrun, 0);

        // Overrun set / clear / set-wins
        do_reset();
        start_frame(34'h1_2345_6789);
        run_until(11, 0, 10, -1, 34'h3_0F0F_0F0F);
        check("t4_ovr_set", overrun, 1);
        run_until(16, 0, -1, 15, '0);
        check("t4_ovr_clr", overrun, 0);
        run_until(21, 0, 20, 20, 34'h0_FFFF_0000);
        check("t4_ovr_win", overrun, 1);
        run_until(34, 0, -1, -1, '0);
        tail();
        check("t4_value", g_val[33:0], 34'h1_2345_6789);
        check("t4_ndone", g_ndone, 1);
        check("t4_cnt", frame_cnt, 1);
        check("t4_ovr_end", overrun, 1);

        // Reset mid-frame at bit 15
        do_reset();
        start_frame(34'h0_DEAD_BEEF);
        run_until(15, 0, -1, -1, '0);
        rst = 1;
        #1;
        check("t5_valid_drop", out_valid, 0);
        repeat (2) begin
            @(negedge clk);
            check("t5_no_done", done, 0);
        end
        check("t5_cnt", frame_cnt, 0);
        @(posedge clk); #1 rst = 0;
        start_frame(34'h2_5A5A_C3C3);
        run_until(34, 0, -1, -1, '0);
        tail();
        check("t5_value", g_val[33:0], 34'h2_5A5A_C3C3);
        check("t5_cnt_after", frame_cnt, 1);
        check("t5_ndone", g_ndone, 1);

        // Counter wrap on the 2-bit instance
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            start_frame(34'h1_0000_0001 * k);
            run_until(34, 0, -1, -1, '0);
            tail();
            check("t6_cnt_w2", frame_cnt2, wrap_exp[k-1]);
            check("t6_cnt", frame_cnt, k);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
